// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared constants for the small CNN pipeline: pixel width, conv output map
// dimensions, lane count of the pooling stage and the argmax window-position
// encoding. The encoding is {row, col} inside a 2x2 window, so bit 1 is the
// row bit and bit 0 is the column bit.
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int DATA_W     = 8;
    localparam int CONV_OUT_W = 6;
    localparam int CONV_OUT_H = 6;
    localparam int NUM_LANES  = 2;

    localparam logic [1:0] TL = 2'd0;
    localparam logic [1:0] TR = 2'd1;
    localparam logic [1:0] BL = 2'd2;
    localparam logic [1:0] BR = 2'd3;

endpackage

// File: rtl/max2_unit.sv
// -----------------------------------------------------------------------------
// max2_unit
// Unsigned two-input max with a tag that follows the winner.
// b only wins on a strict '>', so a tie keeps a (the earlier pixel).
// Ports:
//   a, b          in   DATA_W  operands (a is the earlier / preferred one)
//   a_tag, b_tag  in   TAG_W   tags travelling with a and b
//   max           out  DATA_W  larger operand
//   win_tag       out  TAG_W   tag of the selected operand
// -----------------------------------------------------------------------------
module max2_unit #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [TAG_W-1:0]  a_tag,
    input  logic [TAG_W-1:0]  b_tag,
    output logic [DATA_W-1:0] max,
    output logic [TAG_W-1:0]  win_tag
);

    logic b_wins;

    assign b_wins  = (b > a);
    assign max     = b_wins ? b : a;
    assign win_tag = b_wins ? b_tag : a_tag;

endmodule

// File: rtl/maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream
// Streaming 2x2 / stride-2 max-pool over raster-ordered feature maps, two
// channels in parallel. A horizontal max of each pixel pair is formed on odd
// columns; on even rows it is parked in a half-width line buffer, on odd rows
// it is combined with the parked value and registered as the pooled pixel.
//
// Optional feature: define MAXPOOL_ARGMAX_EN to add argmax_0/argmax_1, the
// winning window position (TL=0, TR=1, BL=2, BR=3, ties -> lowest position).
//
// Ports:
//   clk                          in   clock, all state on rising edge
//   reset                        in   synchronous, active-high
//   input_data_0/1               in   DATA_W pixel per channel
//   input_valid                  in   beat qualifier (gaps allowed)
//   output_data_0/1              out  DATA_W pooled pixel per channel (held)
//   output_valid                 out  one-cycle pulse per pooled pixel
//   out_index                    out  raster index of the pooled pixel
//   frame_done                   out  pulses with the last pooled pixel
//   argmax_0/1 (ARGMAX only)     out  2-bit winning position per channel
// -----------------------------------------------------------------------------
module maxpool2x2_stream #(
    parameter  int DATA_W = nn_pkg::DATA_W,
    parameter  int IN_W   = nn_pkg::CONV_OUT_W,
    parameter  int IN_H   = nn_pkg::CONV_OUT_H,
    localparam int OUT_N  = IN_W * IN_H / 4,
    localparam int IDX_W  = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_data_0,
    input  logic [DATA_W-1:0] input_data_1,
    input  logic              input_valid,
    output logic [DATA_W-1:0] output_data_0,
    output logic [DATA_W-1:0] output_data_1,
    output logic              output_valid,
    output logic [IDX_W-1:0]  out_index,
    output logic              frame_done
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [1:0]        argmax_0,
    output logic [1:0]        argmax_1
`endif
);

    import nn_pkg::*;

    localparam int LANES    = NUM_LANES;
    localparam int HALF_W   = IN_W / 2;
    localparam int COL_W    = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_W    = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int LB_AW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int LAST_IDX = OUT_N - 1;

    if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_w
        $error("maxpool2x2_stream: IN_W must be even and non-zero");
    end
    if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_h
        $error("maxpool2x2_stream: IN_H must be even and non-zero");
    end

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [LB_AW-1:0] lb_addr;
    logic [IDX_W-1:0] cur_idx;

    logic [LANES-1:0][DATA_W-1:0]             in_lane;
    logic [LANES-1:0][DATA_W-1:0]             hold;
    logic [LANES-1:0][DATA_W-1:0]             hmax;
    logic [LANES-1:0][DATA_W-1:0]             lb_rd;
    logic [LANES-1:0][DATA_W-1:0]             pooled;
    logic [LANES-1:0][HALF_W-1:0][DATA_W-1:0] linebuf;

`ifdef MAXPOOL_ARGMAX_EN
    logic [LANES-1:0]             htag;
    logic [LANES-1:0]             lb_tag_rd;
    logic [LANES-1:0][1:0]        vtag;
    logic [LANES-1:0][HALF_W-1:0] lb_tag;
`else
    logic [LANES-1:0][1:0]        tag_unused;
`endif

    assign in_lane[0] = input_data_0;
    assign in_lane[1] = input_data_1;
    assign lb_addr    = LB_AW'(col >> 1);
    assign cur_idx    = IDX_W'((int'(row) >> 1) * HALF_W + (int'(col) >> 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lb_rd[l] = linebuf[l][lb_addr];
`ifdef MAXPOOL_ARGMAX_EN
        // Held pixel is always the left column (tag 0), the live one the right.
        assign lb_tag_rd[l] = lb_tag[l][lb_addr];
        max2_unit #(.DATA_W(DATA_W), .TAG_W(1)) u_hmax (
            .a(hold[l]), .b(in_lane[l]), .a_tag(1'b0), .b_tag(1'b1),
            .max(hmax[l]), .win_tag(htag[l])
        );
        // Top row value is the earlier one, so vertical ties stay on top.
        max2_unit #(.DATA_W(DATA_W), .TAG_W(2)) u_vmax (
            .a(lb_rd[l]), .b(hmax[l]),
            .a_tag({TL[1], lb_tag_rd[l]}), .b_tag({BL[1], htag[l]}),
            .max(pooled[l]), .win_tag(vtag[l])
        );
`else
        max2_unit #(.DATA_W(DATA_W), .TAG_W(1)) u_hmax (
            .a(hold[l]), .b(in_lane[l]), .a_tag(1'b0), .b_tag(1'b0),
            .max(hmax[l]), .win_tag(tag_unused[l][0])
        );
        max2_unit #(.DATA_W(DATA_W), .TAG_W(1)) u_vmax (
            .a(lb_rd[l]), .b(hmax[l]), .a_tag(1'b0), .b_tag(1'b0),
            .max(pooled[l]), .win_tag(tag_unused[l][1])
        );
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col           <= '0;
            row           <= '0;
            hold          <= '0;
            linebuf       <= '0;
            output_data_0 <= '0;
            output_data_1 <= '0;
            output_valid  <= 1'b0;
            out_index     <= '0;
            frame_done    <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
            lb_tag        <= '0;
            argmax_0      <= '0;
            argmax_1      <= '0;
`endif
        end else begin
            output_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (input_valid) begin
                // Raster counters; frames run back-to-back with no idle beat.
                if (col == COL_W'(IN_W - 1)) begin
                    col <= '0;
                    row <= (row == ROW_W'(IN_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    hold <= in_lane;
                end else if (!row[0]) begin
                    for (int l = 0; l < LANES; l++) begin
                        linebuf[l][lb_addr] <= hmax[l];
`ifdef MAXPOOL_ARGMAX_EN
                        lb_tag[l][lb_addr]  <= htag[l];
`endif
                    end
                end else begin
                    // Bottom-right pixel of a window: emit the pooled result.
                    output_data_0 <= pooled[0];
                    output_data_1 <= pooled[1];
                    output_valid  <= 1'b1;
                    out_index     <= cur_idx;
                    frame_done    <= (cur_idx == IDX_W'(LAST_IDX));
`ifdef MAXPOOL_ARGMAX_EN
                    argmax_0      <= vtag[0];
                    argmax_1      <= vtag[1];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool2x2_stream
// Directed bench for maxpool2x2_stream with the default 6x6 map: ramp frame,
// a table of hand-built windows, gapped back-to-back random frames, a
// cross-channel isolation frame and a mid-frame reset.
// -----------------------------------------------------------------------------
module tb_maxpool2x2_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d0, d1;
    logic       in_valid;
    logic [7:0] o0, o1;
    logic       ov;
    logic [3:0] oidx;
    logic       fd;
`ifdef MAXPOOL_ARGMAX_EN
    logic [1:0] am0, am1;
`endif

    always #5 clk = ~clk;

    maxpool2x2_stream dut (
        .clk           (clk),
        .reset         (reset),
        .input_data_0  (d0),
        .input_data_1  (d1),
        .input_valid   (in_valid),
        .output_data_0 (o0),
        .output_data_1 (o1),
        .output_valid  (ov),
        .out_index     (oidx),
        .frame_done    (fd)
`ifdef MAXPOOL_ARGMAX_EN
        ,
        .argmax_0      (am0),
        .argmax_1      (am1)
`endif
    );

    typedef struct {
        logic [7:0] tl, tr, bl, br;
        logic [7:0] exp_max;
        logic [1:0] exp_am;
    } win_t;

    int errors = 0;
    int checks = 0;

    // Captured pulses
    logic [7:0] q0[$], q1[$];
    int         qi[$], qf[$], qa0[$], qa1[$];
    int         pulses = 0, fd_pulses = 0, bad_pulses = 0;
    bit         watch = 1'b0;

    // Current frame and its expected pooled results
    logic [7:0] f0[36], f1[36];
    logic [7:0] e0[18], e1[18];
    int         ea0[18], ea1[18];

    always @(negedge clk) begin
        if (ov === 1'b1) begin
            q0.push_back(o0);
            q1.push_back(o1);
            qi.push_back(int'(oidx));
            qf.push_back(int'(fd));
`ifdef MAXPOOL_ARGMAX_EN
            qa0.push_back(int'(am0));
            qa1.push_back(int'(am1));
`else
            qa0.push_back(0);
            qa1.push_back(0);
`endif
            pulses++;
            if (fd === 1'b1) fd_pulses++;
            if (watch) bad_pulses++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference pool: first occurrence of the maximum in TL,TR,BL,BR order.
    function automatic logic [9:0] pool4(input logic [7:0] tl, tr, bl, br);
        logic [7:0] m;
        logic [1:0] p;
        m = tl; p = 2'd0;
        if (tr > m) begin m = tr; p = 2'd1; end
        if (bl > m) begin m = bl; p = 2'd2; end
        if (br > m) begin m = br; p = 2'd3; end
        return {p, m};
    endfunction

    task automatic build_expected(input int off);
        logic [9:0] r;
        int base;
        for (int k = 0; k < 9; k++) begin
            base = (k / 3) * 12 + (k % 3) * 2;
            r = pool4(f0[base], f0[base+1], f0[base+6], f0[base+7]);
            e0[off+k] = r[7:0]; ea0[off+k] = int'(r[9:8]);
            r = pool4(f1[base], f1[base+1], f1[base+6], f1[base+7]);
            e1[off+k] = r[7:0]; ea1[off+k] = int'(r[9:8]);
        end
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        d0 = a;
        d1 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct);
        for (int i = 0; i < 36; i++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            beat(f0[i], f1[i]);
        end
    endtask

    task automatic flush_queues();
        q0.delete(); q1.delete(); qi.delete(); qf.delete();
        qa0.delete(); qa1.delete();
    endtask

    task automatic check_pulses(input string name, input int n);
        repeat (3) @(posedge clk);
        #1;
        chk({name, " pulse count"}, q0.size(), n);
        for (int k = 0; k < n && k < q0.size(); k++) begin
            chk($sformatf("%s ch0[%0d]", name, k), int'(q0[k]), int'(e0[k]));
            chk($sformatf("%s ch1[%0d]", name, k), int'(q1[k]), int'(e1[k]));
            chk($sformatf("%s index[%0d]", name, k), qi[k], k % 9);
            chk($sformatf("%s frame_done[%0d]", name, k), qf[k], (k % 9 == 8) ? 1 : 0);
`ifdef MAXPOOL_ARGMAX_EN
            chk($sformatf("%s argmax0[%0d]", name, k), qa0[k], ea0[k]);
            chk($sformatf("%s argmax1[%0d]", name, k), qa1[k], ea1[k]);
`endif
        end
        flush_queues();
    endtask

    task automatic set_ramp();
        logic [7:0] ramp_exp[9];
        ramp_exp = '{8'd7, 8'd9, 8'd11, 8'd19, 8'd21, 8'd23, 8'd31, 8'd33, 8'd35};
        for (int i = 0; i < 36; i++) begin
            f0[i] = 8'(i);
            f1[i] = 8'(i);
        end
        for (int k = 0; k < 9; k++) begin
            e0[k] = ramp_exp[k]; e1[k] = ramp_exp[k];
            ea0[k] = 3; ea1[k] = 3;
        end
    endtask

    initial begin
        win_t tbl[9];
        int   base;
        int   fd_before;

        tbl[0] = '{tl: 8'd5,   tr: 8'd5,   bl: 8'd5,   br: 8'd5,   exp_max: 8'd5,   exp_am: 2'd0};
        tbl[1] = '{tl: 8'd10,  tr: 8'd40,  bl: 8'd40,  br: 8'd10,  exp_max: 8'd40,  exp_am: 2'd1};
        tbl[2] = '{tl: 8'd9,   tr: 8'd8,   bl: 8'd7,   br: 8'd6,   exp_max: 8'd9,   exp_am: 2'd0};
        tbl[3] = '{tl: 8'd0,   tr: 8'd0,   bl: 8'd0,   br: 8'd0,   exp_max: 8'd0,   exp_am: 2'd0};
        tbl[4] = '{tl: 8'd1,   tr: 8'd2,   bl: 8'd200, br: 8'd3,   exp_max: 8'd200, exp_am: 2'd2};
        tbl[5] = '{tl: 8'd255, tr: 8'd254, bl: 8'd255, br: 8'd255, exp_max: 8'd255, exp_am: 2'd0};
        tbl[6] = '{tl: 8'd3,   tr: 8'd7,   bl: 8'd7,   br: 8'd7,   exp_max: 8'd7,   exp_am: 2'd1};
        tbl[7] = '{tl: 8'd0,   tr: 8'd0,   bl: 8'd0,   br: 8'd1,   exp_max: 8'd1,   exp_am: 2'd3};
        tbl[8] = '{tl: 8'd100, tr: 8'd100, bl: 8'd101, br: 8'd101, exp_max: 8'd101, exp_am: 2'd2};

        reset = 1'b1; in_valid = 1'b0; d0 = '0; d1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", int'(ov), 0);
        chk("reset ch0", int'(o0), 0);
        chk("reset ch1", int'(o1), 0);
        chk("reset index", int'(oidx), 0);
        chk("reset frame_done", int'(fd), 0);
`ifdef MAXPOOL_ARGMAX_EN
        chk("reset argmax0", int'(am0), 0);
        chk("reset argmax1", int'(am1), 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Ramp frame, gap-free, with latency probes around window 0.
        set_ramp();
        for (int i = 0; i < 36; i++) begin
            beat(f0[i], f1[i]);
            if (i == 6) chk("no pulse before BR", int'(ov), 0);
            if (i == 7) begin
                chk("latency valid", int'(ov), 1);
                chk("latency ch0", int'(o0), 7);
            end
            if (i == 8) begin
                chk("pulse drops", int'(ov), 0);
                chk("held ch0", int'(o0), 7);
            end
        end
        check_pulses("ramp", 9);

        // Hand-built windows: ch0 from the table, ch1 is the bit-inverse.
        for (int k = 0; k < 9; k++) begin
            base = (k / 3) * 12 + (k % 3) * 2;
            f0[base] = tbl[k].tl;  f0[base+1] = tbl[k].tr;
            f0[base+6] = tbl[k].bl; f0[base+7] = tbl[k].br;
        end
        for (int i = 0; i < 36; i++) f1[i] = ~f0[i];
        build_expected(0);
        for (int k = 0; k < 9; k++) begin
            e0[k]  = tbl[k].exp_max;
            ea0[k] = int'(tbl[k].exp_am);
        end
        send_frame(0);
        check_pulses("table", 9);

        // Two random frames back-to-back with ~50% input gaps.
        fd_before = fd_pulses;
        for (int i = 0; i < 36; i++) begin
            f0[i] = 8'($urandom_range(0, 255));
            f1[i] = 8'($urandom_range(0, 3));
        end
        build_expected(0);
        send_frame(50);
        for (int i = 0; i < 36; i++) begin
            f0[i] = 8'($urandom_range(0, 255));
            f1[i] = 8'($urandom_range(0, 3));
        end
        build_expected(9);
        send_frame(50);
        check_pulses("gapped", 18);
        chk("gapped frame_done count", fd_pulses - fd_before, 2);

        // Channel isolation.
        for (int i = 0; i < 36; i++) begin
            f0[i] = 8'd255;
            f1[i] = 8'd0;
        end
        build_expected(0);
        send_frame(0);
        check_pulses("isolation", 9);

        // Reset after 20 beats of a ramp, then a clean ramp frame.
        set_ramp();
        for (int i = 0; i < 20; i++) beat(f0[i], f1[i]);
        reset = 1'b1;
        @(posedge clk);
        #1 watch = 1'b1;
        chk("midreset valid", int'(ov), 0);
        chk("midreset ch0", int'(o0), 0);
        chk("midreset index", int'(oidx), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 watch = 1'b0;
        chk("pulses around reset", bad_pulses, 0);
        flush_queues();
        send_frame(0);
        check_pulses("post-reset ramp", 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
